// File: rtl/pipelined_add_sub.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshake.
// The WIDTH-bit operation is split into STAGES segments of SEG bits; stage k
// resolves bits [k*SEG +: SEG] and registers the carry for stage k+1.
// A single global enable advances or freezes the whole pipe, bubbles included.
module pipelined_add_sub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SEG = WIDTH / STAGES;

  logic en;
  logic last_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still unconsumed on entry to this stage, and sum bits done after it.
    localparam int unsigned IW   = WIDTH - k * SEG;
    localparam int unsigned DONE = (k + 1) * SEG;

    logic            v_d;
    logic [IW-1:0]   a_d;
    logic [IW-1:0]   b_d;
    logic            c_d;
    logic [DONE-1:0] s_nxt;
    logic [SEG:0]    seg;

    logic            v_q;
    logic            c_q;
    logic [DONE-1:0] s_q;

    // Stage 0 captures the ports (inverting b in sub mode); later stages read the previous stage.
    if (k == 0) begin : g_in
      assign v_d   = in_valid;
      assign a_d   = a;
      assign b_d   = b ^ {WIDTH{sub}};
      assign c_d   = cin;
      assign s_nxt = seg[SEG-1:0];
    end else begin : g_link
      assign v_d   = g_stage[k-1].v_q;
      assign a_d   = g_stage[k-1].g_fwd.a_q;
      assign b_d   = g_stage[k-1].g_fwd.b_q;
      assign c_d   = g_stage[k-1].c_q;
      assign s_nxt = {seg[SEG-1:0], g_stage[k-1].s_q};
    end

    // Segment add: lowest SEG unconsumed bits plus the incoming carry.
    always_comb begin
      seg = {1'b0, a_d[SEG-1:0]} + {1'b0, b_d[SEG-1:0]} + {{SEG{1'b0}}, c_d};
    end

    // Valid, carry and completed-sum registers; all frozen when the pipe stalls.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_d;
        c_q <= seg[SEG];
        s_q <= s_nxt;
      end
    end

    // Delay line for the operand segments later stages still need.
    if (k < STAGES - 1) begin : g_fwd
      logic [IW-SEG-1:0] a_q;
      logic [IW-SEG-1:0] b_q;

      // Shift the unconsumed upper operand bits down to the next stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_d[IW-1:SEG];
          b_q <= b_d[IW-1:SEG];
        end
      end
    end

    // Signed overflow: operand signs agree but the result sign differs
    // (equivalent to carry-in XOR carry-out of the MSB).
    if (k == STAGES - 1) begin : g_last
      logic ovf_q;

      // Register the overflow flag alongside the final segment.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= (a_d[SEG-1] == b_d[SEG-1]) && (seg[SEG-1] != a_d[SEG-1]);
        end
      end
    end
  end

  assign last_valid = g_stage[STAGES-1].v_q;
  assign en         = out_ready | ~last_valid;
  assign in_ready   = en;
  assign out_valid  = last_valid;
  assign sum        = g_stage[STAGES-1].s_q;
  assign cout       = g_stage[STAGES-1].c_q;
  assign ovf        = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: a 32/4 instance for the functional
// scenarios plus four instances at other WIDTH/STAGES points for a random sweep.
module tb_pipelined_add_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  // Sweep instances share valid/sub/cin and take slices of 64-bit random operands.
  logic        sw_valid, sw_ready, sw_sub, sw_cin;
  logic [63:0] sw_a, sw_b;
  logic        r8, r16, r64, r32, v8, v16, v64, v32;
  logic        c8, c16, c64, c32, o8, o16, o64, o32;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [63:0] s64;
  logic [31:0] s32;

  pipelined_add_sub #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r8),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .sub(sw_sub), .cin(sw_cin), .out_valid(v8),
    .out_ready(sw_ready), .sum(s8), .cout(c8), .ovf(o8)
  );
  pipelined_add_sub #(.WIDTH(16), .STAGES(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r16),
    .a(sw_a[15:0]), .b(sw_b[15:0]), .sub(sw_sub), .cin(sw_cin), .out_valid(v16),
    .out_ready(sw_ready), .sum(s16), .cout(c16), .ovf(o16)
  );
  pipelined_add_sub #(.WIDTH(64), .STAGES(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r64),
    .a(sw_a), .b(sw_b), .sub(sw_sub), .cin(sw_cin), .out_valid(v64),
    .out_ready(sw_ready), .sum(s64), .cout(c64), .ovf(o64)
  );
  pipelined_add_sub #(.WIDTH(32), .STAGES(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r32),
    .a(sw_a[31:0]), .b(sw_b[31:0]), .sub(sw_sub), .cin(sw_cin), .out_valid(v32),
    .out_ready(sw_ready), .sum(s32), .cout(c32), .ovf(o32)
  );

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
    int          t;
  } exp_t;

  exp_t q8[$], q16[$], q64[$], q32[$];

  // Reference: a + (b ^ {w{sub}}) + cin at width w, with carry and signed overflow.
  function automatic exp_t ref_op(int unsigned w, logic [63:0] x, logic [63:0] y,
                                  logic s, logic c, int t);
    exp_t        e;
    logic [64:0] r;
    logic [63:0] mask, yx;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    yx   = (s ? ~y : y) & mask;
    r    = {1'b0, x & mask} + {1'b0, yx} + {64'd0, c};
    e.s  = r[63:0] & mask;
    e.c  = r[w];
    e.o  = (x[w-1] == yx[w-1]) && (r[w-1] != x[w-1]);
    e.t  = t;
    return e;
  endfunction

  // Issue one op into an empty pipe and wait (bounded) for its result.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                        input logic tc, output logic [31:0] rs, output logic rc,
                        output logic ro, output int lat);
    out_ready = 1'b1;
    a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rc = cout; ro = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    sw_valid = 1'b0; sw_ready = 1'b1; sw_sub = 1'b0; sw_cin = 1'b0; sw_a = '0; sw_b = '0;
    #12;
    vectors++;
    if ({out_valid, sum, cout, ovf} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got valid=%b sum=%h cout=%b ovf=%b want all 0",
               out_valid, sum, cout, ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_defaults();
    logic [31:0] rs; logic rc, ro; int lat;
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, rs, rc, ro, lat);
    vectors++;
    if (rs !== 32'h0 || rc !== 1'b1 || ro !== 1'b0 || lat != 3) begin
      miscompares++;
      $display("FAIL defaults got sum=%h cout=%b ovf=%b lat=%0d want 0/1/0 lat=3", rs, rc, ro, lat);
    end
  endtask

  task automatic test_subtract();
    logic [31:0] rs; logic rc, ro; int lat;
    run_op(32'd5, 32'd7, 1'b1, 1'b1, rs, rc, ro, lat);
    vectors++;
    if (rs !== 32'hFFFF_FFFE || rc !== 1'b0 || ro !== 1'b0 || lat != 3) begin
      miscompares++;
      $display("FAIL sub_5_7 got sum=%h cout=%b ovf=%b lat=%0d want fffffffe/0/0 lat=3", rs, rc, ro, lat);
    end
    run_op(32'h8000_0000, 32'd1, 1'b1, 1'b1, rs, rc, ro, lat);
    vectors++;
    if (rs !== 32'h7FFF_FFFF || rc !== 1'b1 || ro !== 1'b1 || lat != 3) begin
      miscompares++;
      $display("FAIL sub_min_1 got sum=%h cout=%b ovf=%b lat=%0d want 7fffffff/1/1 lat=3", rs, rc, ro, lat);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rs; logic rc, ro; int lat;
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, rs, rc, ro, lat);
    vectors++;
    if (rs !== 32'h8000_0000 || rc !== 1'b0 || ro !== 1'b1) begin
      miscompares++;
      $display("FAIL add_ovf got sum=%h cout=%b ovf=%b want 80000000/0/1", rs, rc, ro);
    end
    run_op(32'h0FFF_FFFF, 32'd0, 1'b0, 1'b1, rs, rc, ro, lat);
    vectors++;
    if (rs !== 32'h1000_0000 || rc !== 1'b0 || ro !== 1'b0) begin
      miscompares++;
      $display("FAIL ripple_cin got sum=%h cout=%b ovf=%b want 10000000/0/0", rs, rc, ro);
    end
  endtask

  task automatic test_back_to_back();
    int issued = 0, got = 0, cycles = 0;
    logic held = 1'b0, accepted;
    logic [31:0] hs; logic hc, ho;
    @(posedge clk); #1;
    in_valid = 1'b1; a = 32'd0; b = 32'd0; sub = 1'b0; cin = 1'b0;
    while (got < 20 && cycles < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (held) begin
        vectors++;
        if (out_valid !== 1'b1 || sum !== hs || cout !== hc || ovf !== ho) begin
          miscompares++;
          $display("FAIL stall_stable got v=%b sum=%h want v=1 sum=%h", out_valid, sum, hs);
        end
      end
      vectors++;
      if (in_ready !== (out_ready | ~out_valid)) begin
        miscompares++;
        $display("FAIL in_ready_en got %b want %b", in_ready, out_ready | ~out_valid);
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (sum !== 32'(2 * got) || cout !== 1'b0 || ovf !== 1'b0) begin
          miscompares++;
          $display("FAIL stream_%0d got sum=%h cout=%b ovf=%b want %h/0/0", got, sum, cout, ovf, 32'(2 * got));
        end
        got++;
        held = 1'b0;
      end else if (out_valid) begin
        held = 1'b1; hs = sum; hc = cout; ho = ovf;
      end else begin
        held = 1'b0;
      end
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
      if (accepted) begin
        issued++;
        if (issued < 20) begin
          a = 32'(issued); b = 32'(issued);
        end else begin
          in_valid = 1'b0;
        end
      end
      cycles++;
    end
    vectors++;
    if (got != 20) begin
      miscompares++;
      $display("FAIL stream_count got %0d results want 20 (timeout)", got);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stream_extra got out_valid=%b sum=%h want no further result", out_valid, sum);
      end
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'(100 + i); b = 32'd1; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_valid got %b want 0", out_valid);
    end
    #9 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_stale got out_valid=1 sum=%h want no result", sum);
      end
    end
  endtask

  task automatic drive_sweep(input int t);
    sw_a = {$urandom, $urandom};
    sw_b = {$urandom, $urandom};
    sw_sub = 1'($urandom_range(0, 1));
    sw_cin = 1'($urandom_range(0, 1));
    sw_valid = 1'b1;
    q8.push_back(ref_op(8, sw_a, sw_b, sw_sub, sw_cin, t));
    q16.push_back(ref_op(16, sw_a, sw_b, sw_sub, sw_cin, t));
    q64.push_back(ref_op(64, sw_a, sw_b, sw_sub, sw_cin, t));
    q32.push_back(ref_op(32, sw_a, sw_b, sw_sub, sw_cin, t));
  endtask

  task automatic test_param_sweep();
    exp_t e;
    sw_ready = 1'b1;
    drive_sweep(0);
    for (int ed = 0; ed < 1040; ed++) begin
      @(posedge clk); #1;
      if (v8) begin
        vectors++;
        e = (q8.size() != 0) ? q8.pop_front() : '{64'd0, 1'b0, 1'b0, -100};
        if ({s8, c8, o8} !== {e.s[7:0], e.c, e.o} || ed - e.t != 0) begin
          miscompares++;
          $display("FAIL sweep8 edge%0d got %h/%b/%b want %h/%b/%b issued%0d", ed, s8, c8, o8, e.s[7:0], e.c, e.o, e.t);
        end
      end
      if (v16) begin
        vectors++;
        e = (q16.size() != 0) ? q16.pop_front() : '{64'd0, 1'b0, 1'b0, -100};
        if ({s16, c16, o16} !== {e.s[15:0], e.c, e.o} || ed - e.t != 1) begin
          miscompares++;
          $display("FAIL sweep16 edge%0d got %h/%b/%b want %h/%b/%b issued%0d", ed, s16, c16, o16, e.s[15:0], e.c, e.o, e.t);
        end
      end
      if (v64) begin
        vectors++;
        e = (q64.size() != 0) ? q64.pop_front() : '{64'd0, 1'b0, 1'b0, -100};
        if ({s64, c64, o64} !== {e.s, e.c, e.o} || ed - e.t != 7) begin
          miscompares++;
          $display("FAIL sweep64 edge%0d got %h/%b/%b want %h/%b/%b issued%0d", ed, s64, c64, o64, e.s, e.c, e.o, e.t);
        end
      end
      if (v32) begin
        vectors++;
        e = (q32.size() != 0) ? q32.pop_front() : '{64'd0, 1'b0, 1'b0, -100};
        if ({s32, c32, o32} !== {e.s[31:0], e.c, e.o} || ed - e.t != 31) begin
          miscompares++;
          $display("FAIL sweep32 edge%0d got %h/%b/%b want %h/%b/%b issued%0d", ed, s32, c32, o32, e.s[31:0], e.c, e.o, e.t);
        end
      end
      if (ed + 1 < 1000) drive_sweep(ed + 1);
      else sw_valid = 1'b0;
    end
    vectors++;
    if (q8.size() + q16.size() + q64.size() + q32.size() != 0) begin
      miscompares++;
      $display("FAIL sweep_drain got pending %0d/%0d/%0d/%0d want 0/0/0/0",
               q8.size(), q16.size(), q64.size(), q32.size());
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_subtract();
    test_overflow();
    test_back_to_back();
    test_reset_midflight();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
